reflet_inst_dump16: RTL and testbench
=====================================

# reflet_inst_dump16

Read-back engine for the 16-bit instruction memory: on command it reads a block of words from instruction RAM and streams them out as a byte stream, low byte first, followed by a one-byte two's-complement checksum trailer. It sits between the instruction-memory read port and a byte-wide transmit channel such as a UART TX or debug link. It is the reader counterpart of the boot-time initialiser that writes the instruction memory, and it lets the host verify a loaded program.

## Interface
- addr_size, 15, word address width of instruction memory
- count_size, 16, width of word_count; max block = 2^addr_size words
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- inst_ready  in  1  instruction memory initialised; commands are ignored while low
- start  in  1  one-cycle command strobe
- base_addr  in  addr_size  first word address, sampled on accepted start
- word_count  in  count_size  number of words, sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the trailer byte is transferred
- mem_addr  out  addr_size  read address, driven from the internal address register
- mem_enable  out  1  read strobe; high only in FETCH
- mem_data  in  16  read data, valid the cycle after mem_enable
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts; a byte transfers on an edge where tx_valid && tx_ready
- checksum  out  8  running 8-bit sum of data bytes sent; holds final value after done

## Operation
- States: IDLE, FETCH, CAPTURE, SEND_LO, SEND_HI, SEND_SUM.
- IDLE: start && inst_ready latches cur_addr=base_addr, remaining=word_count, clears sum to 0, and moves to FETCH, or to SEND_SUM if word_count==0. start is ignored in every other state and whenever inst_ready==0.
- FETCH: mem_enable=1, mem_addr=cur_addr. Moves to CAPTURE unconditionally.
- CAPTURE: latches mem_data into word_buf, increments cur_addr modulo 2^addr_size (0x7FFF wraps to 0x0000), decrements remaining. Moves to SEND_LO.
- SEND_LO: tx_data=word_buf[7:0], tx_valid=1. On transfer, sum += byte (mod 256) and the state moves to SEND_HI.
- SEND_HI: tx_data=word_buf[15:8]. On transfer, sum += byte and the state moves to FETCH if remaining!=0, else to SEND_SUM.
- SEND_SUM: tx_data=(~sum+1) mod 256, so all bytes including the trailer sum to 0 mod 256. On transfer, done=1 for one cycle and the state moves to IDLE. The trailer is not added to checksum.
- tx_data and tx_valid are stable while tx_valid && !tx_ready. No memory access occurs during a stall.
- inst_ready falling mid-transfer has no effect; the transfer completes.
- Reset, at any time including mid-transfer: state IDLE, busy=0, done=0, tx_valid=0, tx_data=0, mem_enable=0, mem_addr=0, checksum=0, word_buf=0. No partial byte is emitted after reset.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from tx_ready or mem_data to any output.
- Start accepted at edge T: FETCH during cycle T+1, CAPTURE at T+2, first tx_valid at T+3.
- With tx_ready held high, throughput is 4 cycles per word (FETCH, CAPTURE, LO, HI) plus 1 trailer cycle. Example: N words take 4N+1 cycles from FETCH entry to done.
- done is asserted in the cycle after the trailer transfer edge; busy falls in that same cycle.
- mem_data is sampled only at the CAPTURE edge.

## Test plan
- mem[0x0010]=0x1234, mem[0x0011]=0xABCD, start with base 0x0010, count 2, tx_ready=1 -> bytes 34,12,CD,AB,42 on consecutive accepted cycles; checksum=0xBE; done pulses once; 2 mem_enable pulses, at 0x0010 and 0x0011.
- Same as above with tx_ready low for 3 cycles while SEND_HI shows 0x12 -> tx_data stays 0x12 and tx_valid stays 1; no mem_enable during the stall; final stream unchanged.
- base 0x7FFF, count 2, mem[0x7FFF]=0x00FF, mem[0x0000]=0x0001 -> mem_addr 0x7FFF then 0x0000; bytes FF,00,01,00,00; checksum 0x00.
- count 0 -> single byte 0x00, no mem_enable, done; start with inst_ready=0 -> nothing happens; second start while busy -> ignored, original stream intact.
- Reset asserted during SEND_HI of a 4-word dump -> next cycle all outputs at their reset values; a subsequent start of count 1 produces a correct 3-byte stream.

Source files
------------

// File: rtl/reflet_inst_dump16_if.sv
// reflet_inst_dump16_if
//   Bundles the command, instruction-memory read port and byte-stream
//   transmit signals of the instruction-memory read-back engine.
//   Command:  inst_ready, start, base_addr, word_count -> busy, done, checksum
//   Memory:   mem_addr, mem_enable -> mem_data (one-cycle read latency)
//   Stream:   tx_data, tx_valid -> tx_ready
//   slave  : the read-back engine's view
//   master : the surrounding system's view (host, memory, transmit sink)
interface reflet_inst_dump16_if #(
  parameter int addr_size  = 15,
  parameter int count_size = 16
);
  logic                  inst_ready;
  logic                  start;
  logic [addr_size-1:0]  base_addr;
  logic [count_size-1:0] word_count;
  logic                  busy;
  logic                  done;
  logic [addr_size-1:0]  mem_addr;
  logic                  mem_enable;
  logic [15:0]           mem_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            checksum;

  modport slave (
    input  inst_ready, start, base_addr, word_count, mem_data, tx_ready,
    output busy, done, mem_addr, mem_enable, tx_data, tx_valid, checksum
  );

  modport master (
    output inst_ready, start, base_addr, word_count, mem_data, tx_ready,
    input  busy, done, mem_addr, mem_enable, tx_data, tx_valid, checksum
  );
endinterface

// File: rtl/reflet_inst_dump16.sv
// reflet_inst_dump16
//   Reads a block of 16-bit words from instruction memory and streams them
//   out as bytes (low byte first), followed by a one-byte two's-complement
//   checksum trailer so that every byte of the stream sums to 0 mod 256.
//   Ports:
//     clk    - clock
//     reset  - synchronous, active-low reset
//     bus    - reflet_inst_dump16_if.slave: command (start/base_addr/
//              word_count/inst_ready), status (busy/done/checksum),
//              memory read port (mem_addr/mem_enable/mem_data) and
//              byte stream (tx_data/tx_valid/tx_ready)
module reflet_inst_dump16 #(
  parameter int addr_size  = 15,
  parameter int count_size = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  reflet_inst_dump16_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    CAPTURE  = 3'd2,
    SEND_LO  = 3'd3,
    SEND_HI  = 3'd4,
    SEND_SUM = 3'd5
  } state_t;

  localparam logic [addr_size-1:0]  ADDR_ONE  = {{(addr_size-1){1'b0}}, 1'b1};
  localparam logic [count_size-1:0] COUNT_ONE = {{(count_size-1){1'b0}}, 1'b1};

  state_t                state_reg, state_next;
  logic [addr_size-1:0]  cur_addr_reg;
  logic [count_size-1:0] remaining_reg;
  logic [15:0]           word_buf_reg;
  logic [7:0]            sum_reg;
  logic                  done_reg;

  logic start_ok;
  logic tx_fire;

  assign start_ok = bus.start && bus.inst_ready;
  // tx_valid is high in exactly the three SEND states, so a transfer is
  // simply tx_ready seen while in one of them.
  assign tx_fire  = bus.tx_ready &&
                    (state_reg == SEND_LO || state_reg == SEND_HI ||
                     state_reg == SEND_SUM);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok)
          state_next = (bus.word_count == '0) ? SEND_SUM : FETCH;
      end
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = SEND_LO;
      SEND_LO: if (tx_fire) state_next = SEND_HI;
      SEND_HI: begin
        // remaining was already decremented in CAPTURE
        if (tx_fire) state_next = (remaining_reg != '0) ? FETCH : SEND_SUM;
      end
      SEND_SUM: if (tx_fire) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      word_buf_reg  <= '0;
      sum_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            cur_addr_reg  <= bus.base_addr;
            remaining_reg <= bus.word_count;
            sum_reg       <= '0;
          end
        end
        CAPTURE: begin
          word_buf_reg  <= bus.mem_data;
          // natural overflow gives the modulo-2^addr_size wrap
          cur_addr_reg  <= cur_addr_reg + ADDR_ONE;
          remaining_reg <= remaining_reg - COUNT_ONE;
        end
        SEND_LO:  if (tx_fire) sum_reg <= sum_reg + word_buf_reg[7:0];
        SEND_HI:  if (tx_fire) sum_reg <= sum_reg + word_buf_reg[15:8];
        SEND_SUM: if (tx_fire) done_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    bus.mem_enable = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.busy       = (state_reg != IDLE);
    case (state_reg)
      FETCH:   bus.mem_enable = 1'b1;
      SEND_LO: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = word_buf_reg[7:0];
      end
      SEND_HI: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = word_buf_reg[15:8];
      end
      SEND_SUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = ~sum_reg + 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = cur_addr_reg;
  assign bus.checksum = sum_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_reflet_inst_dump16.sv
module tb_reflet_inst_dump16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reflet_inst_dump16_if #(.addr_size(15), .count_size(16)) bus ();

  reflet_inst_dump16 #(.addr_size(15), .count_size(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [0:32767];

  int checks = 0;
  int errors = 0;

  int exp_q[$];       // expected stream bytes
  int exp_addr_q[$];  // expected memory read addresses
  int exp_sum;        // expected final checksum of current dump

  bit rand_ready = 1'b0;
  int stall_req  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Instruction memory: registered read, data valid the cycle after mem_enable
  initial begin
    bus.mem_data = 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.mem_enable) bus.mem_data <= mem[bus.mem_addr];
    end
  end

  // Transmit sink ready driver
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0) begin
        bus.tx_ready = 1'b0;
        stall_req--;
      end else if (rand_ready) begin
        bus.tx_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reads memory or a byte transfers
  initial begin
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_stall) begin
          chk("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
          chk("stall_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
        end
        if (bus.tx_valid && !bus.tx_ready)
          chk("stall_no_mem", {31'd0, bus.mem_enable}, 32'd0);
        if (bus.mem_enable) begin
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_addr: got unexpected read at 0x%0h expected none", bus.mem_addr);
          end else begin
            chk("mem_addr", {17'd0, bus.mem_addr}, exp_addr_q.pop_front());
          end
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_byte: got unexpected byte 0x%0h expected none", bus.tx_data);
          end else begin
            chk("tx_byte", {24'd0, bus.tx_data}, exp_q.pop_front());
          end
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Reference model: compute the whole expected stream, then pulse start.
  // Returns just after the edge at which start is accepted.
  task automatic issue(input logic [14:0] base, input logic [15:0] cnt);
    int s = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      int a;
      int w;
      a = (int'(base) + i) % 32768;
      w = int'(mem[a]);
      exp_addr_q.push_back(a);
      exp_q.push_back(w % 256);
      exp_q.push_back(w / 256);
      s += (w % 256) + (w / 256);
    end
    exp_q.push_back((256 - (s % 256)) % 256);
    exp_sum = s % 256;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  // Wait for done; exp_edges / exp_first < 0 skip the timing checks
  task automatic wait_done(input int exp_edges, input int exp_first);
    int edges = 0;
    int first = -1;
    bit seen  = 1'b0;
    while (!seen && edges < 500) begin
      @(negedge clk);
      if (bus.tx_valid && first < 0) first = edges;
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      chk("checksum", {24'd0, bus.checksum}, exp_sum);
      chk("stream_drained", exp_q.size(), 32'd0);
      chk("reads_drained", exp_addr_q.size(), 32'd0);
      if (exp_edges >= 0) chk("done_latency", edges, exp_edges);
      if (exp_first >= 0) chk("first_valid", first, exp_first);
      @(negedge clk);
      chk("done_pulse", {31'd0, bus.done}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, bus.done}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 32'd0);
    chk({tag, "_tx_data"},  {24'd0, bus.tx_data}, 32'd0);
    chk({tag, "_mem_en"},   {31'd0, bus.mem_enable}, 32'd0);
    chk({tag, "_mem_addr"}, {17'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_checksum"}, {24'd0, bus.checksum}, 32'd0);
  endtask

  initial begin
    bus.inst_ready = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'h1234;
    mem[16'h0011] = 16'hABCD;
    mem[16'h7FFF] = 16'h00FF;
    mem[16'h0000] = 16'h0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic two-word dump
    issue(15'h0010, 16'd2);
    wait_done(9, 2);
    chk("basic_checksum", {24'd0, bus.checksum}, 32'h0000_00BE);

    // Stall while SEND_HI shows 0x12
    issue(15'h0010, 16'd2);
    begin
      int guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!(bus.tx_valid && bus.tx_data == 8'h34) && guard < 20);
      chk("stall_setup", {31'd0, bus.tx_valid}, 32'd1);
      stall_req = 3;
      @(posedge clk);
      repeat (3) begin
        @(negedge clk);
        chk("stall_hi_data", {24'd0, bus.tx_data}, 32'h12);
        chk("stall_hi_ready", {31'd0, bus.tx_ready}, 32'd0);
      end
    end
    wait_done(-1, -1);
    chk("stall_checksum", {24'd0, bus.checksum}, 32'h0000_00BE);

    // Address wrap
    issue(15'h7FFF, 16'd2);
    wait_done(9, 2);

    // Zero-length dump
    issue(15'h1234, 16'd0);
    wait_done(1, 0);

    // start ignored while inst_ready is low
    bus.inst_ready = 1'b0;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = 15'h0100;
    bus.word_count = 16'd3;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("noready_busy", {31'd0, bus.busy}, 32'd0);
    end
    bus.inst_ready = 1'b1;

    // Second start while busy is ignored; inst_ready dropping mid-transfer too
    issue(15'h0020, 16'd3);
    repeat (2) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.base_addr  = 15'h0200;
    bus.word_count = 16'd7;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.inst_ready = 1'b0;
    wait_done(-1, -1);
    bus.inst_ready = 1'b1;

    // Reset during SEND_HI of a 4-word dump
    issue(15'h0400, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_valid", {31'd0, bus.tx_valid}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    issue(15'h0500, 16'd1);
    wait_done(5, 2);

    // Randomized dumps
    for (int n = 0; n < 25; n++) begin
      logic [14:0] base;
      logic [15:0] cnt;
      base = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFC + 15'($urandom_range(0, 3)))
                                         : 15'($urandom);
      cnt  = 16'($urandom_range(0, 6));
      rand_ready = ($urandom_range(0, 1) == 1);
      issue(base, cnt);
      wait_done(rand_ready ? -1 : 4 * int'(cnt) + 1, (cnt == 16'd0) ? 0 : 2);
    end
    rand_ready = 1'b0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
